mem_1w1r_be_pipe: RTL and testbench

- Single-clock, parametrised 1-write/1-read register-file memory; next generation of the dual-clock 1W1R FIFO storage in the AXI slave datapath.
- Adds per-byte write enables, configurable read latency (1 or 2), a read-valid strobe, and optional same-address write-to-read bypass.
- Used as payload storage for write-data/read-data buffers inside the XSPI AXI slave, where both pointers live in one clock domain.

---
 rtl/mem_1w1r_be_pipe_pkg.sv | 16 +
 rtl/mem_1w1r_be_pipe_if.sv | 46 ++++
 rtl/mem_1w1r_be_pipe_rd_pipe.sv | 62 ++++++
 rtl/mem_1w1r_be_pipe.sv | 150 +++++++++++++++
 tb/tb_mem_1w1r_be_pipe.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_1w1r_be_pipe_pkg.sv
// Shared constants and helpers for the 1W1R byte-enable register-file memory.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: byte width, legal read-latency bounds, even-parity helper.
package mem_1w1r_pkg;

   localparam int BYTE_W     = 8;
   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 2;

   // Even parity: the returned bit makes the total count of ones even.
   function automatic logic byte_parity(input logic [BYTE_W-1:0] i_byte);
      return ^i_byte;
   endfunction

endpackage

// File: rtl/mem_1w1r_be_pipe_if.sv
// Request/response bundle between a 1W1R memory user (master) and the memory (slave).
// Latency: n/a (wiring only).
// Backpressure: none; the memory accepts one write and one read every cycle.
// Signals: waddr/wen/wbe/wdata write port, raddr/ren read request, rdata/rvalid response.
// With MEM_1W1R_PARITY_EN defined: wpar_inv (parity error injection) and rperr (per-lane parity error).
interface mem_1w1r_be_pipe_if
   import mem_1w1r_pkg::*;
#(
   parameter int PTR_WIDTH  = 3,
   parameter int DATA_WIDTH = 32
);
   localparam int BE_WIDTH = DATA_WIDTH / BYTE_W;

   logic [PTR_WIDTH-1:0]  waddr;
   logic                  wen;
   logic [BE_WIDTH-1:0]   wbe;
   logic [DATA_WIDTH-1:0] wdata;
   logic [PTR_WIDTH-1:0]  raddr;
   logic                  ren;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  rvalid;

`ifdef MEM_1W1R_PARITY_EN
   logic [BE_WIDTH-1:0]   wpar_inv;
   logic [BE_WIDTH-1:0]   rperr;

   modport master (
      output waddr, wen, wbe, wdata, wpar_inv, raddr, ren,
      input  rdata, rvalid, rperr
   );
   modport slave (
      input  waddr, wen, wbe, wdata, wpar_inv, raddr, ren,
      output rdata, rvalid, rperr
   );
`else
   modport master (
      output waddr, wen, wbe, wdata, raddr, ren,
      input  rdata, rvalid
   );
   modport slave (
      input  waddr, wen, wbe, wdata, raddr, ren,
      output rdata, rvalid
   );
`endif

endinterface

// File: rtl/mem_1w1r_be_pipe_rd_pipe.sv
// Read-result pipeline: carries a valid strobe plus payload through 1 or 2 register stages.
// Latency: RD_LATENCY cycles from i_vld to o_vld.
// Backpressure: none; accepts one result per cycle, payload holds while no valid passes.
// Ports: clk, rst (sync, active-high), i_vld/i_dat in, o_vld/o_dat out.
module mem_1w1r_rd_pipe
   import mem_1w1r_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int RD_LATENCY = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_vld,
   input  logic [WIDTH-1:0] i_dat,
   output logic             o_vld,
   output logic [WIDTH-1:0] o_dat
);

   if (RD_LATENCY < RD_LAT_MIN || RD_LATENCY > RD_LAT_MAX) begin : g_bad_latency
      $error("mem_1w1r_rd_pipe: RD_LATENCY must be 1 or 2");
   end

   logic             r_s1_vld;
   logic [WIDTH-1:0] r_s1_dat;

   // Payload only loads on a valid so the output holds its last result.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_vld <= 1'b0;
         r_s1_dat <= '0;
      end else begin
         r_s1_vld <= i_vld;
         if (i_vld) begin
            r_s1_dat <= i_dat;
         end
      end
   end

   if (RD_LATENCY == RD_LAT_MAX) begin : g_two_stage
      logic             r_s2_vld;
      logic [WIDTH-1:0] r_s2_dat;

      always_ff @(posedge clk) begin
         if (rst) begin
            r_s2_vld <= 1'b0;
            r_s2_dat <= '0;
         end else begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
               r_s2_dat <= r_s1_dat;
            end
         end
      end

      assign o_vld = r_s2_vld;
      assign o_dat = r_s2_dat;
   end else begin : g_one_stage
      assign o_vld = r_s1_vld;
      assign o_dat = r_s1_dat;
   end

endmodule

// File: rtl/mem_1w1r_be_pipe.sv
// Single-clock 1W1R register-file memory with byte enables, optional write-to-read bypass.
// Latency: RD_LATENCY (1 or 2) cycles from ren to rdata/rvalid; writes land on the wen edge.
// Backpressure: none; one write and one read accepted every cycle, throughput 1.
// Ports: clk, rst (sync, active-high), bus (mem_1w1r_be_pipe_if.slave).
// Optional MEM_1W1R_PARITY_EN: per-lane even parity storage, wpar_inv injection, rperr output.
// Storage is not reset; only the read pipeline and outputs clear on rst.
module mem_1w1r_be_pipe
   import mem_1w1r_pkg::*;
#(
   parameter int PTR_WIDTH  = 3,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8,
   parameter int RD_LATENCY = 1,
   parameter int WR_BYPASS  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   mem_1w1r_be_pipe_if.slave     bus
);

   localparam int BE_WIDTH = DATA_WIDTH / BYTE_W;

   if (RD_LATENCY < RD_LAT_MIN || RD_LATENCY > RD_LAT_MAX) begin : g_bad_latency
      $error("mem_1w1r_be_pipe: RD_LATENCY must be 1 or 2");
   end
   if (DATA_WIDTH % BYTE_W != 0) begin : g_bad_width
      $error("mem_1w1r_be_pipe: DATA_WIDTH must be a multiple of 8");
   end
   if (DEPTH < 1 || DEPTH > (1 << PTR_WIDTH)) begin : g_bad_depth
      $error("mem_1w1r_be_pipe: DEPTH must be in 1..2**PTR_WIDTH");
   end

   // One extra bit so DEPTH == 2**PTR_WIDTH still compares correctly.
   localparam logic [PTR_WIDTH:0] LP_DEPTH  = (PTR_WIDTH + 1)'(DEPTH);
   localparam logic               LP_BYPASS = (WR_BYPASS != 0);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   logic                  w_wr_in_rng;
   logic                  w_rd_in_rng;
   logic                  w_rd_fire;
   logic                  w_bypass;
   logic [DATA_WIDTH-1:0] w_old_word;
   logic [DATA_WIDTH-1:0] w_rd_word;

   assign w_wr_in_rng = ({1'b0, bus.waddr} < LP_DEPTH);
   assign w_rd_in_rng = ({1'b0, bus.raddr} < LP_DEPTH);
   assign w_rd_fire   = bus.ren & ~rst;

   // Same-cycle same-address collision; the in-range check on waddr covers raddr too.
   assign w_bypass = LP_BYPASS & bus.wen & bus.ren & w_wr_in_rng & (bus.waddr == bus.raddr);

   // Byte-lane write; out-of-range addresses and rst cycles leave the array untouched.
   always_ff @(posedge clk) begin
      if (!rst && bus.wen && w_wr_in_rng) begin
         for (int i = 0; i < BE_WIDTH; i++) begin
            if (bus.wbe[i]) begin
               r_mem[bus.waddr][i*BYTE_W +: BYTE_W] <= bus.wdata[i*BYTE_W +: BYTE_W];
            end
         end
      end
   end

   // Out-of-range reads return zero; bypassed lanes take the incoming write bytes.
   always_comb begin
      w_old_word = '0;
      if (w_rd_in_rng) begin
         w_old_word = r_mem[bus.raddr];
      end
      w_rd_word = w_old_word;
      for (int i = 0; i < BE_WIDTH; i++) begin
         if (w_bypass && bus.wbe[i]) begin
            w_rd_word[i*BYTE_W +: BYTE_W] = bus.wdata[i*BYTE_W +: BYTE_W];
         end
      end
   end

`ifdef MEM_1W1R_PARITY_EN
   localparam int LP_PIPE_W = DATA_WIDTH + BE_WIDTH;

   logic [BE_WIDTH-1:0] r_par [DEPTH];
   logic [BE_WIDTH-1:0] w_wr_par;
   logic [BE_WIDTH-1:0] w_old_par;
   logic [BE_WIDTH-1:0] w_rd_par;
   logic [BE_WIDTH-1:0] w_rd_perr;

   // Stored parity is the true even parity, optionally flipped to inject an error.
   always_comb begin
      w_wr_par = '0;
      for (int i = 0; i < BE_WIDTH; i++) begin
         w_wr_par[i] = byte_parity(bus.wdata[i*BYTE_W +: BYTE_W]) ^ bus.wpar_inv[i];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && bus.wen && w_wr_in_rng) begin
         for (int i = 0; i < BE_WIDTH; i++) begin
            if (bus.wbe[i]) begin
               r_par[bus.waddr][i] <= w_wr_par[i];
            end
         end
      end
   end

   // Zero data with zero parity on out-of-range reads yields no error.
   always_comb begin
      w_old_par = '0;
      if (w_rd_in_rng) begin
         w_old_par = r_par[bus.raddr];
      end
      w_rd_par  = w_old_par;
      w_rd_perr = '0;
      for (int i = 0; i < BE_WIDTH; i++) begin
         if (w_bypass && bus.wbe[i]) begin
            w_rd_par[i] = w_wr_par[i];
         end
         w_rd_perr[i] = byte_parity(w_rd_word[i*BYTE_W +: BYTE_W]) ^ w_rd_par[i];
      end
   end

   logic [LP_PIPE_W-1:0] w_pipe_in;
   logic [LP_PIPE_W-1:0] w_pipe_out;

   assign w_pipe_in               = {w_rd_word, w_rd_perr};
   assign {bus.rdata, bus.rperr}  = w_pipe_out;
`else
   localparam int LP_PIPE_W = DATA_WIDTH;

   logic [LP_PIPE_W-1:0] w_pipe_in;
   logic [LP_PIPE_W-1:0] w_pipe_out;

   assign w_pipe_in = w_rd_word;
   assign bus.rdata = w_pipe_out;
`endif

   // Array is sampled on the ren edge; later stages never look at the array again,
   // so a write landing while a read is in flight cannot alter that result.
   mem_1w1r_rd_pipe #(
      .WIDTH      (LP_PIPE_W),
      .RD_LATENCY (RD_LATENCY)
   ) u_rd_pipe (
      .clk   (clk),
      .rst   (rst),
      .i_vld (w_rd_fire),
      .i_dat (w_pipe_in),
      .o_vld (bus.rvalid),
      .o_dat (w_pipe_out)
   );

endmodule

// File: tb/tb_mem_1w1r_be_pipe.sv
// Bench for mem_1w1r_be_pipe: two instances share one stimulus stream.
// dut_a: DEPTH=6, RD_LATENCY=1, WR_BYPASS=1.  dut_b: DEPTH=6, RD_LATENCY=2, WR_BYPASS=0.
// Expected read results are queued with their due cycle when the read is driven.
module tb_mem_1w1r_be_pipe;

   localparam int PW    = 3;
   localparam int DW    = 32;
   localparam int DEPTH = 6;
   localparam int LAT_A = 1;
   localparam int LAT_B = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_1w1r_be_pipe_if #(.PTR_WIDTH(PW), .DATA_WIDTH(DW)) ifa ();
   mem_1w1r_be_pipe_if #(.PTR_WIDTH(PW), .DATA_WIDTH(DW)) ifb ();

   assign ifb.waddr = ifa.waddr;
   assign ifb.wen   = ifa.wen;
   assign ifb.wbe   = ifa.wbe;
   assign ifb.wdata = ifa.wdata;
   assign ifb.raddr = ifa.raddr;
   assign ifb.ren   = ifa.ren;

   logic [3:0] perr_a;
   logic [3:0] perr_b;
`ifdef MEM_1W1R_PARITY_EN
   assign ifb.wpar_inv = ifa.wpar_inv;
   assign perr_a = ifa.rperr;
   assign perr_b = ifb.rperr;
`else
   assign perr_a = 4'd0;
   assign perr_b = 4'd0;
`endif

   mem_1w1r_be_pipe #(
      .PTR_WIDTH(PW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RD_LATENCY(LAT_A), .WR_BYPASS(1)
   ) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa.slave)
   );

   mem_1w1r_be_pipe #(
      .PTR_WIDTH(PW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RD_LATENCY(LAT_B), .WR_BYPASS(0)
   ) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb.slave)
   );

   typedef struct {
      int          id;
      int          due;
      logic [31:0] dat;
      logic [3:0]  perr;
   } ent_t;

   ent_t        sbq[$];
   int          cyc    = 0;
   logic        rst_q  = 1'b1;
   int          tests  = 0;
   int          fails  = 0;
   bit          mon_en = 1'b0;
   logic [31:0] last_dat  [2];
   logic [3:0]  last_perr [2];

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= rst;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Per-cycle output check for one instance. A reset edge discards whatever was in flight.
   task automatic mon(input int id, input logic vld, input logic [31:0] dat, input logic [3:0] perr);
      int          idx;
      logic        exp_v;
      logic [31:0] exp_d;
      logic [3:0]  exp_p;
      string       nm;
      nm    = (id == 0) ? "a" : "b";
      idx   = -1;
      exp_v = 1'b0;
      exp_d = last_dat[id];
      exp_p = last_perr[id];
      if (rst_q) begin
         for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].id == id && sbq[i].due <= cyc) sbq.delete(i);
         end
         exp_d = '0;
         exp_p = '0;
      end else begin
         for (int i = 0; i < sbq.size(); i++) begin
            if (sbq[i].id == id) begin
               idx = i;
               break;
            end
         end
         if (idx >= 0 && sbq[idx].due == cyc) begin
            exp_v = 1'b1;
            exp_d = sbq[idx].dat;
            exp_p = sbq[idx].perr;
            sbq.delete(idx);
         end
      end
      chk({"rvalid_", nm}, {31'd0, vld}, {31'd0, exp_v});
      chk({"rdata_", nm}, dat, exp_d);
`ifdef MEM_1W1R_PARITY_EN
      chk({"rperr_", nm}, {28'd0, perr}, {28'd0, exp_p});
`else
      if (perr !== 4'd0) chk({"rperr_", nm}, {28'd0, perr}, 32'd0);
`endif
      last_dat[id]  = exp_d;
      last_perr[id] = exp_p;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         mon(0, ifa.rvalid, ifa.rdata, perr_a);
         mon(1, ifb.rvalid, ifb.rdata, perr_b);
      end
   end

   // One cycle of stimulus, applied 2 time units after the rising edge.
   task automatic tick(input logic r, input logic we, input logic [2:0] wa, input logic [3:0] be,
                       input logic [31:0] wd, input logic [3:0] pinv, input logic re,
                       input logic [2:0] ra, input logic [31:0] ea, input logic [31:0] eb,
                       input logic [3:0] ep);
      ent_t e;
      @(posedge clk);
      #2;
      rst       = r;
      ifa.wen   = we;
      ifa.waddr = wa;
      ifa.wbe   = be;
      ifa.wdata = wd;
      ifa.ren   = re;
      ifa.raddr = ra;
`ifdef MEM_1W1R_PARITY_EN
      ifa.wpar_inv = pinv;
`else
      if (pinv != 4'd0) ifa.wbe = be;
`endif
      if (re && !r) begin
         e.id = 0; e.due = cyc + LAT_A; e.dat = ea; e.perr = ep;
         sbq.push_back(e);
         e.id = 1; e.due = cyc + LAT_B; e.dat = eb; e.perr = ep;
         sbq.push_back(e);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be,
                     input logic [3:0] pinv = 4'd0);
      tick(1'b0, 1'b1, a, be, d, pinv, 1'b0, 3'd0, 32'd0, 32'd0, 4'd0);
   endtask

   task automatic rd(input logic [2:0] a, input logic [31:0] ea, input logic [31:0] eb,
                     input logic [3:0] ep = 4'd0);
      tick(1'b0, 1'b0, 3'd0, 4'd0, 32'd0, 4'd0, 1'b1, a, ea, eb, ep);
   endtask

   task automatic idle(input int n, input logic r = 1'b0);
      for (int k = 0; k < n; k++) begin
         tick(r, 1'b0, 3'd0, 4'd0, 32'd0, 4'd0, 1'b0, 3'd0, 32'd0, 32'd0, 4'd0);
      end
   endtask

   function automatic logic [31:0] init_word(input int i);
      return 32'hC0DE_0000 | 32'(i * 17 + 3);
   endfunction

   initial begin
      ifa.wen   = 1'b0;
      ifa.waddr = '0;
      ifa.wbe   = '0;
      ifa.wdata = '0;
      ifa.ren   = 1'b0;
      ifa.raddr = '0;
`ifdef MEM_1W1R_PARITY_EN
      ifa.wpar_inv = '0;
`endif
      last_dat[0] = '0; last_dat[1] = '0;
      last_perr[0] = '0; last_perr[1] = '0;
      mon_en = 1'b1;

      idle(3, 1'b1);

      // Known contents everywhere so later unchanged-word checks are meaningful.
      for (int i = 0; i < DEPTH; i++) wr(3'(i), init_word(i), 4'hF);

      // Full-word write then read; latency checked through the due cycle.
      wr(3'd3, 32'hA5A5_1234, 4'hF);
      rd(3'd3, 32'hA5A5_1234, 32'hA5A5_1234);

      // Single-lane update.
      wr(3'd5, 32'hFFFF_FFFF, 4'hF);
      wr(3'd5, 32'h0000_00AA, 4'h1);
      rd(3'd5, 32'hFFFF_FFAA, 32'hFFFF_FFAA);

      // wen with no byte enables changes nothing.
      wr(3'd0, 32'h5555_5555, 4'h0);
      rd(3'd0, init_word(0), init_word(0));

      // Same-cycle collision: bypass on dut_a, old word on dut_b; write completes in both.
      wr(3'd2, 32'h1111_1111, 4'hF);
      tick(1'b0, 1'b1, 3'd2, 4'h3, 32'h2222_2222, 4'd0, 1'b1, 3'd2,
           32'h1111_2222, 32'h1111_1111, 4'd0);
      rd(3'd2, 32'h1111_2222, 32'h1111_2222);

      // Out-of-range writes dropped, out-of-range reads give rvalid with zero data.
      wr(3'd7, 32'hDEAD_BEEF, 4'hF);
      wr(3'd6, 32'hCAFE_F00D, 4'hF);
      rd(3'd7, 32'd0, 32'd0);
      rd(3'd6, 32'd0, 32'd0);

      // Back-to-back reads over the whole array, no bubbles.
      rd(3'd0, init_word(0), init_word(0));
      rd(3'd1, init_word(1), init_word(1));
      rd(3'd2, 32'h1111_2222, 32'h1111_2222);
      rd(3'd3, 32'hA5A5_1234, 32'hA5A5_1234);
      rd(3'd4, init_word(4), init_word(4));
      rd(3'd5, 32'hFFFF_FFAA, 32'hFFFF_FFAA);

      // Idle cycles: rdata must hold the last result with rvalid low.
      idle(3);

      // Reset in the cycle after three consecutive reads; a write and read in that cycle are ignored.
      rd(3'd1, init_word(1), init_word(1));
      rd(3'd2, 32'h1111_2222, 32'h1111_2222);
      rd(3'd3, 32'hA5A5_1234, 32'hA5A5_1234);
      tick(1'b1, 1'b1, 3'd1, 4'hF, 32'h0BAD_0BAD, 4'd0, 1'b1, 3'd1, 32'd0, 32'd0, 4'd0);
      idle(2);
      rd(3'd1, init_word(1), init_word(1));
      idle(3);

`ifdef MEM_1W1R_PARITY_EN
      // Parity error injection on lane 2, then clean rewrite.
      wr(3'd4, 32'h1234_5678, 4'hF, 4'h4);
      rd(3'd4, 32'h1234_5678, 32'h1234_5678, 4'h4);
      wr(3'd4, 32'h1234_5678, 4'hF, 4'h0);
      rd(3'd4, 32'h1234_5678, 32'h1234_5678, 4'h0);
      idle(3);
`endif

      idle(4);
      chk("sb_empty", 32'(sbq.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
